rob_commit_unit: RTL and testbench
==================================

Name: rob_commit_unit

Overview:
- Reorder buffer that sits between the instruction decoder and the register file.
- Accepts decoded instructions on a valid/accept handshake and allocates a ROB tag to each one.
- Captures execution results from the common data bus (CDB) and retires entries strictly in program order.
- Each retirement drives a one-cycle commit write-back to the register file, which clears the register's tag when it still matches the committed tag. Also offers two combinational operand-lookup ports so the decoder can read results that are finished but not yet committed.

Parameters:
- DEPTH, 16, number of ROB entries; must be a power of two.
- TAG_W, 4, tag width; equals log2(DEPTH).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  global enable; all state holds while low.
- clr  in  1  synchronous flush from flow control.
- dispatch_valid  in  1  decoder presents an instruction.
- dispatch_rd  in  5  destination register index.
- dispatch_writes_rd  in  1  instruction writes rd (0 for store and branch).
- success  out  1  dispatch accepted this cycle (combinational).
- alloc_tag  out  TAG_W  tag assigned to the instruction accepted this cycle (combinational, equals tail).
- cdb_valid  in  1  execution result valid.
- cdb_tag  in  TAG_W  tag of the result.
- cdb_value  in  32  result value.
- query_tag_j  in  TAG_W  operand lookup tag, port j.
- query_tag_k  in  TAG_W  operand lookup tag, port k.
- query_done_j  out  1  port j entry is busy and done (combinational).
- query_done_k  out  1  port k entry is busy and done (combinational).
- query_value_j  out  32  port j entry value (combinational).
- query_value_k  out  32  port k entry value (combinational).
- commit_valid  out  1  one-cycle pulse per retired entry (registered).
- commit_we  out  1  register write enable for the commit (registered).
- commit_addr  out  5  committed rd.
- commit_value  out  32  committed value.
- commit_tag  out  TAG_W  tag of the retired entry.

Behaviour:
- Reset (async, rst=1): head=tail=count=0; all busy/done bits 0; all commit_* outputs 0.
- Storage:
  - Per entry: busy, done, rd[4:0], writes_rd, value[31:0].
  - Head/tail pointers are TAG_W bits and wrap modulo DEPTH.
  - count is TAG_W+1 bits.
- Handshake: success = rdy & ~clr & ~rst & (count < DEPTH).
- Allocate: on posedge with dispatch_valid & success:
  - entry[tail] gets busy=1, done=0, rd, writes_rd; tail++.
  - Latency 0: the tag is visible on alloc_tag in the same cycle as success.
- CDB capture: on posedge with cdb_valid & entry[cdb_tag].busy: done=1, value=cdb_value.
  - A result for a non-busy entry is ignored.
  - A repeated result for a done entry overwrites value.
- Retire: on posedge, if entry[head].busy & entry[head].done:
  - next cycle: commit_valid=1, commit_we = writes_rd & (rd != 0), commit_addr=rd, commit_value=value, commit_tag=head;
  - entry[head].busy=0; head++.
  - Otherwise commit_valid=0 and commit_we=0; the other commit_* outputs hold.
  - At most one retirement per cycle.
- CDB result to the head entry: the done bit is registered, so the earliest retirement is the edge after capture. CDB-to-commit_valid latency is 2 edges minimum.
- Simultaneous allocate and retire: count unchanged. Full buffer plus retire in the same cycle: success stays 0 (computed from the current count), so there is no fall-through.
- Count update: count += alloc - retire.
- Query ports: query_done_x = busy[t] & done[t]; query_value_x = value[t].
  - No CDB bypass into the query ports: a same-cycle CDB result is visible on the next cycle.
- clr=1 (with rdy=1):
  - all busy and done cleared; head=tail=count=0; commit_valid=commit_we=0.
  - clr takes priority over allocate, capture and retire in the same cycle.
- rdy=0: pointers, count and entries frozen; no allocate, capture or retire; commit_valid and commit_we forced 0 on that edge.
- Empty buffer: no retirement.

Test Plan:
- Reset, then dispatch rd=5 writes_rd=1: success=1, alloc_tag=0. CDB tag0 value 0x1234. Two edges later: commit_valid=1, commit_we=1, addr=5, value=0x1234, tag=0.
- Dispatch tags 0,1,2 (rd=1,2,3). CDB results in order tag2, tag0, tag1 on consecutive cycles. Commits appear in order tag0, tag1, tag2, on consecutive cycles after tag1 completes.
- Dispatch 16 entries with no CDB: success=0 on the 17th attempt. Complete tag0, then dispatch again the cycle after retirement: alloc_tag wraps to 0.
- Dispatch rd=0 writes_rd=1, and a store with writes_rd=0: both retire with commit_valid=1 and commit_we=0.
- Fill 4 entries, complete 2, assert clr: no commit occurs. Next dispatch gets alloc_tag=0, and a stale CDB result for tag3 is ignored.
- Complete tag0 while rdy=0: no retirement. After rdy=1, commit_valid fires once; query_tag_j=0 shows query_done_j=1, value correct, before retirement.

Source files
------------

// File: rtl/rob_commit_unit.sv
// ============================================================================
// rob_commit_unit -- reorder buffer: tag allocation, CDB capture, in-order commit
// Revision: 1.0
// ============================================================================
`default_nettype none

module rob_commit_unit #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clr,
  input  logic             dispatch_valid,
  input  logic [4:0]       dispatch_rd,
  input  logic             dispatch_writes_rd,
  output logic             success,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  input  logic [TAG_W-1:0] query_tag_j,
  input  logic [TAG_W-1:0] query_tag_k,
  output logic             query_done_j,
  output logic             query_done_k,
  output logic [31:0]      query_value_j,
  output logic [31:0]      query_value_k,
  output logic             commit_valid,
  output logic             commit_we,
  output logic [4:0]       commit_addr,
  output logic [31:0]      commit_value,
  output logic [TAG_W-1:0] commit_tag
);

  localparam logic [TAG_W:0]   CAPACITY = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W-1:0] PTR_ONE  = TAG_W'(1);
  localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W+1)'(1);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] done;
  logic [DEPTH-1:0] writes_mem;
  logic [4:0]       rd_mem  [DEPTH];
  logic [31:0]      val_mem [DEPTH];

  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   count;

  logic active;
  logic do_alloc;
  logic do_capture;
  logic do_retire;

  assign active     = rdy & ~clr;
  assign success    = rdy & ~clr & ~rst & (count < CAPACITY);
  assign alloc_tag  = tail;
  assign do_alloc   = dispatch_valid & success;
  assign do_capture = active & cdb_valid & busy[cdb_tag];
  assign do_retire  = active & busy[head] & done[head];

  // No CDB bypass: lookups see only registered state.
  assign query_done_j  = busy[query_tag_j] & done[query_tag_j];
  assign query_done_k  = busy[query_tag_k] & done[query_tag_k];
  assign query_value_j = val_mem[query_tag_j];
  assign query_value_k = val_mem[query_tag_k];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      busy  <= '0;
      done  <= '0;
    end else if (rdy) begin
      if (clr) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        busy  <= '0;
        done  <= '0;
      end else begin
        if (do_capture) begin
          done[cdb_tag] <= 1'b1;
        end
        // Retire uses the pre-edge done bit, so a capture to head retires next edge.
        if (do_retire) begin
          busy[head] <= 1'b0;
          done[head] <= 1'b0;
          head       <= head + PTR_ONE;
        end
        if (do_alloc) begin
          busy[tail] <= 1'b1;
          done[tail] <= 1'b0;
          tail       <= tail + PTR_ONE;
        end
        if (do_alloc && !do_retire) begin
          count <= count + CNT_ONE;
        end else if (!do_alloc && do_retire) begin
          count <= count - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_alloc) begin
      rd_mem[tail]     <= dispatch_rd;
      writes_mem[tail] <= dispatch_writes_rd;
    end
    if (do_capture) begin
      val_mem[cdb_tag] <= cdb_value;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_valid <= 1'b0;
      commit_we    <= 1'b0;
      commit_addr  <= '0;
      commit_value <= '0;
      commit_tag   <= '0;
    end else begin
      commit_valid <= 1'b0;
      commit_we    <= 1'b0;
      if (do_retire) begin
        commit_valid <= 1'b1;
        commit_we    <= writes_mem[head] & (rd_mem[head] != 5'd0);
        commit_addr  <= rd_mem[head];
        commit_value <= val_mem[head];
        commit_tag   <= head;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rob_commit_unit.sv
// ============================================================================
// tb_rob_commit_unit -- directed checks of the reorder buffer commit unit
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rob_commit_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        clr = 1'b0;
  logic        dispatch_valid = 1'b0;
  logic [4:0]  dispatch_rd = '0;
  logic        dispatch_writes_rd = 1'b0;
  logic        success;
  logic [3:0]  alloc_tag;
  logic        cdb_valid = 1'b0;
  logic [3:0]  cdb_tag = '0;
  logic [31:0] cdb_value = '0;
  logic [3:0]  query_tag_j = '0;
  logic [3:0]  query_tag_k = '0;
  logic        query_done_j;
  logic        query_done_k;
  logic [31:0] query_value_j;
  logic [31:0] query_value_k;
  logic        commit_valid;
  logic        commit_we;
  logic [4:0]  commit_addr;
  logic [31:0] commit_value;
  logic [3:0]  commit_tag;

  int checks = 0;
  int errors = 0;

  rob_commit_unit #(.DEPTH(16), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .dispatch_valid(dispatch_valid), .dispatch_rd(dispatch_rd),
    .dispatch_writes_rd(dispatch_writes_rd),
    .success(success), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .query_tag_j(query_tag_j), .query_tag_k(query_tag_k),
    .query_done_j(query_done_j), .query_done_k(query_done_k),
    .query_value_j(query_value_j), .query_value_k(query_value_k),
    .commit_valid(commit_valid), .commit_we(commit_we),
    .commit_addr(commit_addr), .commit_value(commit_value),
    .commit_tag(commit_tag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_commit(input string tag, input logic v, input logic we,
                            input logic [4:0] a, input logic [31:0] val, input logic [3:0] t);
    chk({tag, "_valid"}, 32'(commit_valid), 32'(v));
    chk({tag, "_we"},    32'(commit_we),    32'(we));
    chk({tag, "_addr"},  32'(commit_addr),  32'(a));
    chk({tag, "_value"}, commit_value,      val);
    chk({tag, "_tag"},   32'(commit_tag),   32'(t));
  endtask

  task automatic flush();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    settle();
  endtask

  task automatic dispatch(input logic [4:0] rd, input logic wr, input logic [3:0] exp_tag);
    dispatch_valid     = 1'b1;
    dispatch_rd        = rd;
    dispatch_writes_rd = wr;
    settle();
    chk("disp_success", 32'(success), 32'd1);
    chk("disp_tag", 32'(alloc_tag), 32'(exp_tag));
    tick();
    dispatch_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk_commit("reset", 1'b0, 1'b0, 5'd0, 32'h0, 4'd0);
    chk("reset_success", 32'(success), 32'd0);
    rst = 1'b0;
    settle();

    // Single instruction: dispatch, capture, commit two edges after CDB
    dispatch(5'd5, 1'b1, 4'd0);
    query_tag_j = 4'd0;
    cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_value = 32'h1234;
    settle();
    chk("q_before_cdb", 32'(query_done_j), 32'd0);
    tick();
    cdb_valid = 1'b0;
    chk("q_after_cdb", 32'(query_done_j), 32'd1);
    chk("q_value", query_value_j, 32'h1234);
    chk("no_commit_yet", 32'(commit_valid), 32'd0);
    tick();
    chk_commit("single", 1'b1, 1'b1, 5'd5, 32'h1234, 4'd0);
    tick();
    chk("single_pulse", 32'(commit_valid), 32'd0);
    chk("single_tag_hold", 32'(commit_tag), 32'd0);

    // Out-of-order completion, in-order commit
    flush();
    dispatch(5'd1, 1'b1, 4'd0);
    dispatch(5'd2, 1'b1, 4'd1);
    dispatch(5'd3, 1'b1, 4'd2);
    cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_value = 32'hA2;
    tick();
    chk("ooo_no_commit0", 32'(commit_valid), 32'd0);
    cdb_tag = 4'd0; cdb_value = 32'hA0;
    tick();
    chk("ooo_no_commit1", 32'(commit_valid), 32'd0);
    cdb_tag = 4'd1; cdb_value = 32'hA1;
    tick();
    cdb_valid = 1'b0;
    chk_commit("ooo_c0", 1'b1, 1'b1, 5'd1, 32'hA0, 4'd0);
    tick();
    chk_commit("ooo_c1", 1'b1, 1'b1, 5'd2, 32'hA1, 4'd1);
    tick();
    chk_commit("ooo_c2", 1'b1, 1'b1, 5'd3, 32'hA2, 4'd2);
    tick();
    chk("ooo_idle", 32'(commit_valid), 32'd0);

    // Fill to capacity, stall, then wrap
    flush();
    for (int i = 0; i < 16; i++) begin
      dispatch(5'(i + 1), 1'b1, 4'(i));
    end
    dispatch_valid = 1'b1; dispatch_rd = 5'd30; dispatch_writes_rd = 1'b1;
    settle();
    chk("full_success", 32'(success), 32'd0);
    tick();
    dispatch_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_value = 32'hC0;
    tick();
    cdb_valid = 1'b0;
    chk("full_still", 32'(success), 32'd0);
    tick();
    chk_commit("full_retire", 1'b1, 1'b1, 5'd1, 32'hC0, 4'd0);
    dispatch(5'd7, 1'b1, 4'd0);
    settle();
    chk("refull_success", 32'(success), 32'd0);

    // rd=0 and store: commit without register write
    flush();
    dispatch(5'd0, 1'b1, 4'd0);
    dispatch(5'd9, 1'b0, 4'd1);
    cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_value = 32'h11;
    tick();
    cdb_tag = 4'd1; cdb_value = 32'h22;
    tick();
    cdb_valid = 1'b0;
    chk_commit("rd0", 1'b1, 1'b0, 5'd0, 32'h11, 4'd0);
    tick();
    chk_commit("store", 1'b1, 1'b0, 5'd9, 32'h22, 4'd1);

    // Flush discards partially completed work
    flush();
    for (int i = 0; i < 4; i++) begin
      dispatch(5'(i + 1), 1'b1, 4'(i));
    end
    cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_value = 32'hB1;
    tick();
    cdb_tag = 4'd2; cdb_value = 32'hB2;
    tick();
    cdb_valid = 1'b0;
    chk("pre_clr_nocommit", 32'(commit_valid), 32'd0);
    clr = 1'b1;
    settle();
    chk("clr_success", 32'(success), 32'd0);
    tick();
    clr = 1'b0;
    chk("clr_nocommit", 32'(commit_valid), 32'd0);
    cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_value = 32'hDEAD;
    dispatch(5'd6, 1'b1, 4'd0);
    cdb_valid = 1'b0;
    query_tag_k = 4'd3;
    query_tag_j = 4'd1;
    settle();
    chk("stale_cdb_k", 32'(query_done_k), 32'd0);
    chk("clr_cleared_j", 32'(query_done_j), 32'd0);
    tick();
    chk("clr_no_retire", 32'(commit_valid), 32'd0);

    // rdy low freezes retirement
    flush();
    dispatch(5'd12, 1'b1, 4'd0);
    cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_value = 32'hF00D;
    query_tag_j = 4'd0;
    tick();
    cdb_valid = 1'b0;
    rdy = 1'b0;
    settle();
    chk("stall_qdone", 32'(query_done_j), 32'd1);
    chk("stall_qval", query_value_j, 32'hF00D);
    chk("stall_success", 32'(success), 32'd0);
    tick();
    chk("stall_nocommit0", 32'(commit_valid), 32'd0);
    tick();
    chk("stall_nocommit1", 32'(commit_valid), 32'd0);
    chk("stall_qdone_hold", 32'(query_done_j), 32'd1);
    rdy = 1'b1;
    tick();
    chk_commit("stall_release", 1'b1, 1'b1, 5'd12, 32'hF00D, 4'd0);
    tick();
    chk("stall_once", 32'(commit_valid), 32'd0);
    chk("stall_qdone_gone", 32'(query_done_j), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
